updown_counter_param: RTL

Parametrised synchronous up/down modulo counter that replaces the fixed 4-bit down counter and its divided-clock scheme. It uses a single clock and an internal prescaler that produces a step enable, so no derived clock exists. It adds selectable direction, parallel load, wrap or saturate mode, and a terminal-count pulse. It drives LED or HEX display logic and sequencing in lab top levels.

---
 rtl/updown_counter_param.sv | 113 +++++++++++
 1 files changed

// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_param
// Summary  : Single-clock up/down modulo counter. An internal prescaler makes
//            a step enable, so there is no derived clock. The counter supports
//            parallel load with clamp, wrap or saturate at the bounds, and
//            registered tick and terminal-count pulses.
//            Optional macro UDCNT_ONESHOT_EN adds a 'done' output. In that
//            mode the counter stops at the first bound it reaches.
// Revision : 1.0 - initial release
// ============================================================================
module updown_counter_param #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int DIV      = 50000000,
    parameter int INIT     = 0,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
`ifdef UDCNT_ONESHOT_EN
    ,
    output logic             done
`endif
);

    // The prescaler is wide enough to hold DIV-1 and is at least one bit wide.
    localparam int               PRE_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [WIDTH:0]   C_MOD      = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] C_TOP      = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] C_INIT     = WIDTH'(INIT);

    logic [PRE_W-1:0] r_pre;
    logic             w_frozen;
    logic             w_hold_bound;
    logic             w_step;
    logic             w_at_bound;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_clamped;

`ifdef UDCNT_ONESHOT_EN
    // After the one-shot run finishes, steps stop and the count stays at the bound.
    assign w_frozen     = done;
    assign w_hold_bound = 1'b1;
`else
    assign w_frozen     = 1'b0;
    assign w_hold_bound = (SATURATE != 0);
`endif

    // Decode the step, the bound condition, the next count and the clamped load value.
    always_comb begin
        w_step         = en & ~w_frozen & (r_pre == C_PRE_LAST);
        w_at_bound     = dir ? (count == '0) : (count == C_TOP);
        // Compare one bit wider so that MODULUS == 2**WIDTH is represented exactly.
        w_load_clamped = ({1'b0, load_val} < C_MOD) ? load_val : C_TOP;
        if (w_at_bound) begin
            w_next = w_hold_bound ? count : (dir ? C_TOP : '0);
        end else begin
            w_next = dir ? (count - 1'b1) : (count + 1'b1);
        end
    end

    // Prescaler. It counts enabled cycles and holds while en is low or after the run is done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
        end else if (load) begin
            r_pre <= '0;
        end else if (en & ~w_frozen) begin
            r_pre <= w_step ? '0 : (r_pre + 1'b1);
        end
    end

    // Count register and its pulses. Priority is reset, then load, then step, then hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= C_INIT;
            tick  <= 1'b0;
            tc    <= 1'b0;
`ifdef UDCNT_ONESHOT_EN
            done  <= 1'b0;
`endif
        end else if (load) begin
            count <= w_load_clamped;
            tick  <= 1'b0;
            tc    <= 1'b0;
`ifdef UDCNT_ONESHOT_EN
            done  <= 1'b0;
`endif
        end else begin
            tick <= w_step;
            tc   <= w_step & w_at_bound;
            if (w_step) begin
                count <= w_next;
            end
`ifdef UDCNT_ONESHOT_EN
            if (w_step & w_at_bound) begin
                done <= 1'b1;
            end
`endif
        end
    end

endmodule
`default_nettype wire
